// File: rtl/decode_scoreboard_if.sv
// Fetch/write-back/execute-facing bus of the decode/operand-read stage.
// Signal names follow the pipeline's established port names; master drives the I_* side.
interface decode_scoreboard_if #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_WB    = 2
);
    localparam int unsigned RIDX_W = $clog2(NUM_REGS);

    logic                        I_FE_Valid;
    logic [31:0]                 I_PC;
    logic [31:0]                 I_IR;
    logic [RIDX_W-1:0]           I_Src1Idx;
    logic [RIDX_W-1:0]           I_Src2Idx;
    logic                        I_Src1Use;
    logic                        I_Src2Use;
    logic [RIDX_W-1:0]           I_DestIdx;
    logic                        I_DestWrite;
    logic                        I_IsBranch;
    logic                        I_BranchResolved;
    logic                        I_GPUStallSignal;
    logic [NUM_WB-1:0]           I_WBEn;
    logic [NUM_WB*RIDX_W-1:0]    I_WBIdx;
    logic [NUM_WB*REG_WIDTH-1:0] I_WBData;

    logic                        O_DE_Valid;
    logic [31:0]                 O_PC;
    logic [31:0]                 O_IR;
    logic [REG_WIDTH-1:0]        O_Src1Value;
    logic [REG_WIDTH-1:0]        O_Src2Value;
    logic [RIDX_W-1:0]           O_DestIdx;
    logic                        O_DestWrite;
    logic                        O_DepStallSignal;
    logic                        O_BranchStallSignal;

    modport master (
        output I_FE_Valid, I_PC, I_IR, I_Src1Idx, I_Src2Idx, I_Src1Use, I_Src2Use,
               I_DestIdx, I_DestWrite, I_IsBranch, I_BranchResolved, I_GPUStallSignal,
               I_WBEn, I_WBIdx, I_WBData,
        input  O_DE_Valid, O_PC, O_IR, O_Src1Value, O_Src2Value, O_DestIdx, O_DestWrite,
               O_DepStallSignal, O_BranchStallSignal
    );

    modport slave (
        input  I_FE_Valid, I_PC, I_IR, I_Src1Idx, I_Src2Idx, I_Src1Use, I_Src2Use,
               I_DestIdx, I_DestWrite, I_IsBranch, I_BranchResolved, I_GPUStallSignal,
               I_WBEn, I_WBIdx, I_WBData,
        output O_DE_Valid, O_PC, O_IR, O_Src1Value, O_Src2Value, O_DestIdx, O_DestWrite,
               O_DepStallSignal, O_BranchStallSignal
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode/operand-read stage: register file, per-register pending-write counters, branch hold FSM.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data and free RAW hazards a cycle early.
module decode_scoreboard #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned PEND_W    = 2
) (
    input logic I_CLOCK,
    input logic I_RESET,
    decode_scoreboard_if.slave bus
);
    localparam int unsigned RIDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W  = $clog2(NUM_WB + 1);
    localparam int unsigned SUM_W  = PEND_W + CNT_W + 1;
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [31:0]       BUBBLE_IR = 32'hFF00_0000;

    typedef enum logic {IDLE, WAIT_BR} br_state_t;

    br_state_t state, state_nxt;

    logic [REG_WIDTH-1:0] rf       [NUM_REGS];
    logic [PEND_W-1:0]    pend     [NUM_REGS];
    logic [PEND_W-1:0]    pend_nxt [NUM_REGS];
    logic [SUM_W-1:0]     pend_sum [NUM_REGS];
    logic [CNT_W-1:0]     dec      [NUM_REGS];

    logic [REG_WIDTH-1:0] src1_val, src2_val;
    logic                 src1_busy, src2_busy, dest_full;
    logic                 dep_stall, issue;

    logic                 de_valid;
    logic [31:0]          de_pc, de_ir;
    logic [REG_WIDTH-1:0] de_src1, de_src2;
    logic [RIDX_W-1:0]    de_dest_idx;
    logic                 de_dest_write;

    // Number of enabled write-back ports targeting each register this cycle.
    always_comb begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            dec[r] = '0;
            for (int k = 0; k < int'(NUM_WB); k++) begin
                if (bus.I_WBEn[k] && bus.I_WBIdx[k*RIDX_W +: RIDX_W] == RIDX_W'(r))
                    dec[r] = dec[r] + CNT_W'(1);
            end
        end
    end

    // Operand values and source hazard status; later ports override earlier ones.
    always_comb begin
        src1_val  = rf[bus.I_Src1Idx];
        src2_val  = rf[bus.I_Src2Idx];
        src1_busy = (pend[bus.I_Src1Idx] != '0);
        src2_busy = (pend[bus.I_Src2Idx] != '0);
`ifdef DECODE_WB_BYPASS_EN
        src1_busy = SUM_W'(pend[bus.I_Src1Idx]) > SUM_W'(dec[bus.I_Src1Idx]);
        src2_busy = SUM_W'(pend[bus.I_Src2Idx]) > SUM_W'(dec[bus.I_Src2Idx]);
        for (int k = 0; k < int'(NUM_WB); k++) begin
            if (bus.I_WBEn[k] && bus.I_WBIdx[k*RIDX_W +: RIDX_W] == bus.I_Src1Idx)
                src1_val = bus.I_WBData[k*REG_WIDTH +: REG_WIDTH];
            if (bus.I_WBEn[k] && bus.I_WBIdx[k*RIDX_W +: RIDX_W] == bus.I_Src2Idx)
                src2_val = bus.I_WBData[k*REG_WIDTH +: REG_WIDTH];
        end
`endif
    end

    assign dest_full = (pend[bus.I_DestIdx] == PEND_MAX);
    assign dep_stall = bus.I_FE_Valid & ((bus.I_Src1Use & src1_busy) |
                                         (bus.I_Src2Use & src2_busy) |
                                         (bus.I_DestWrite & dest_full));
    assign issue     = bus.I_FE_Valid & ~dep_stall & (state == IDLE) & ~bus.I_GPUStallSignal;

    assign bus.O_DepStallSignal    = dep_stall;
    assign bus.O_BranchStallSignal = (state == WAIT_BR) | (bus.I_FE_Valid & bus.I_IsBranch);

    // Net counter change: issue increment minus write-back decrements, floored at zero.
    always_comb begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            pend_sum[r] = SUM_W'(pend[r]) +
                          SUM_W'(issue && bus.I_DestWrite && bus.I_DestIdx == RIDX_W'(r));
            pend_nxt[r] = (pend_sum[r] > SUM_W'(dec[r])) ? PEND_W'(pend_sum[r] - SUM_W'(dec[r]))
                                                         : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue && bus.I_IsBranch) state_nxt = WAIT_BR;
            WAIT_BR: if (bus.I_BranchResolved)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                rf[r]   <= '0;
                pend[r] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_WB); k++) begin
                if (bus.I_WBEn[k])
                    rf[bus.I_WBIdx[k*RIDX_W +: RIDX_W]] <= bus.I_WBData[k*REG_WIDTH +: REG_WIDTH];
            end
            for (int r = 0; r < int'(NUM_REGS); r++) pend[r] <= pend_nxt[r];
        end
    end

    // Decode/execute latch: load on issue, bubble when free, hold under downstream stall.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            de_valid      <= 1'b0;
            de_pc         <= '0;
            de_ir         <= '0;
            de_src1       <= '0;
            de_src2       <= '0;
            de_dest_idx   <= '0;
            de_dest_write <= 1'b0;
        end else if (issue) begin
            de_valid      <= 1'b1;
            de_pc         <= bus.I_PC;
            de_ir         <= bus.I_IR;
            de_src1       <= src1_val;
            de_src2       <= src2_val;
            de_dest_idx   <= bus.I_DestIdx;
            de_dest_write <= bus.I_DestWrite;
        end else if (!bus.I_GPUStallSignal) begin
            de_valid      <= 1'b0;
            de_ir         <= BUBBLE_IR;
            de_dest_write <= 1'b0;
        end
    end

    assign bus.O_DE_Valid  = de_valid;
    assign bus.O_PC        = de_pc;
    assign bus.O_IR        = de_ir;
    assign bus.O_Src1Value = de_src1;
    assign bus.O_Src2Value = de_src2;
    assign bus.O_DestIdx   = de_dest_idx;
    assign bus.O_DestWrite = de_dest_write;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard: stimulus pushes per-edge expected latch contents,
// a monitor pops and compares after every non-held clock edge.
module tb_decode_scoreboard;
    localparam logic [31:0] BUBBLE_IR = 32'hFF00_0000;

    typedef struct {
        logic        full;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  didx;
        logic        dw;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    decode_scoreboard_if bus ();
    decode_scoreboard dut (.I_CLOCK(clk), .I_RESET(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_in();
        bus.I_FE_Valid = 0; bus.I_PC = '0; bus.I_IR = '0;
        bus.I_Src1Idx = '0; bus.I_Src2Idx = '0; bus.I_Src1Use = 0; bus.I_Src2Use = 0;
        bus.I_DestIdx = '0; bus.I_DestWrite = 0; bus.I_IsBranch = 0;
        bus.I_BranchResolved = 0; bus.I_GPUStallSignal = 0;
        bus.I_WBEn = '0; bus.I_WBIdx = '0; bus.I_WBData = '0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] d,
                         input logic dw, input logic br);
        bus.I_FE_Valid = 1; bus.I_PC = pc; bus.I_IR = 32'h1000_0000 | pc;
        bus.I_Src1Idx = s1; bus.I_Src1Use = u1; bus.I_Src2Idx = s2; bus.I_Src2Use = u2;
        bus.I_DestIdx = d; bus.I_DestWrite = dw; bus.I_IsBranch = br;
    endtask

    task automatic wb(input int port, input logic [3:0] idx, input logic [31:0] data);
        bus.I_WBEn[port] = 1'b1;
        bus.I_WBIdx[port*4 +: 4] = idx;
        bus.I_WBData[port*32 +: 32] = data;
    endtask

    // Check stall outputs for the presented inputs, then queue the expected latch result.
    task automatic step(input string name, input logic exp_dep, input logic exp_br,
                        input logic exp_issue, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        #1;
        chk({name, "_dep"}, 32'(bus.O_DepStallSignal), 32'(exp_dep));
        chk({name, "_br"},  32'(bus.O_BranchStallSignal), 32'(exp_br));
        e.full = exp_issue; e.valid = exp_issue;
        e.pc = exp_issue ? bus.I_PC : '0;
        e.ir = exp_issue ? bus.I_IR : BUBBLE_IR;
        e.s1 = e1; e.s2 = e2;
        e.didx = exp_issue ? bus.I_DestIdx : '0;
        e.dw = exp_issue ? bus.I_DestWrite : 1'b0;
        if (exp_issue || !bus.I_GPUStallSignal) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        exp_t e;
        rst = 1;
        e.full = 1; e.valid = 0; e.pc = '0; e.ir = '0; e.s1 = '0; e.s2 = '0; e.didx = '0; e.dw = 0;
        q.push_back(e);
        @(negedge clk);
        rst = 0;
    endtask

    // Monitor: every edge not held by a downstream stall consumes one expectation.
    initial begin
        exp_t e;
        logic r, h;
        forever begin
            @(posedge clk);
            r = rst;
            h = bus.I_GPUStallSignal && !r;
            #1;
            if (!h) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL monitor_underflow: got edge with empty queue, expected none (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("de_valid", 32'(bus.O_DE_Valid), 32'(e.valid));
                    chk("de_ir", bus.O_IR, e.ir);
                    chk("de_dest_write", 32'(bus.O_DestWrite), 32'(e.dw));
                    if (e.full) begin
                        chk("de_pc", bus.O_PC, e.pc);
                        chk("de_src1", bus.O_Src1Value, e.s1);
                        chk("de_src2", bus.O_Src2Value, e.s2);
                        chk("de_dest_idx", 32'(bus.O_DestIdx), 32'(e.didx));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1;
        reset_cycle();
        reset_cycle();

        // ADD R3 <- R1,R2 issues immediately; then a reader of R3 waits on the pending write
        clear_in(); instr(32'h100, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0); step("add", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h104, 4'd3, 1, 4'd0, 0, 4'd6, 1, 0); step("raw_wait", 1, 0, 0, 0, 0);
`ifdef DECODE_WB_BYPASS_EN
        clear_in(); instr(32'h104, 4'd3, 1, 4'd0, 0, 4'd6, 1, 0); wb(0, 4'd3, 32'h1234);
        step("raw_bypass", 0, 0, 1, 32'h1234, 0);
`else
        clear_in(); instr(32'h104, 4'd3, 1, 4'd0, 0, 4'd6, 1, 0); wb(0, 4'd3, 32'h1234);
        step("raw_wb", 1, 0, 0, 0, 0);
        clear_in(); instr(32'h104, 4'd3, 1, 4'd0, 0, 4'd6, 1, 0);
        step("raw_issue", 0, 0, 1, 32'h1234, 0);
`endif
        clear_in(); wb(1, 4'd6, 32'h66); step("wb_r6", 0, 0, 0, 0, 0);

        // Two writers of R5, then both ports retire R5 in one cycle: port1 data wins, count hits 0
        clear_in(); instr(32'h200, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0); step("r5_w1", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h204, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0); step("r5_w2", 0, 0, 1, 0, 0);
        clear_in(); wb(0, 4'd5, 32'd1); wb(1, 4'd5, 32'd2); step("r5_wb2", 0, 0, 0, 0, 0);
        clear_in(); instr(32'h208, 4'd3, 1, 4'd5, 1, 4'd7, 0, 0); step("r5_read", 0, 0, 1, 32'h1234, 32'd2);

        // Counter saturation on R4: fourth writer blocks until a write-back lands
        clear_in(); instr(32'h300, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_w1", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h304, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_w2", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h308, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_w3", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h30C, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_full_a", 1, 0, 0, 0, 0);
        clear_in(); instr(32'h30C, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_full_b", 1, 0, 0, 0, 0);
        clear_in(); instr(32'h30C, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); wb(0, 4'd4, 32'h41);
        step("r4_full_wb", 1, 0, 0, 0, 0);
        clear_in(); instr(32'h30C, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0); step("r4_w4", 0, 0, 1, 0, 0);
        clear_in(); wb(0, 4'd4, 32'h42); wb(1, 4'd4, 32'h43); step("r4_drain2", 0, 0, 0, 0, 0);
        clear_in(); wb(0, 4'd4, 32'h44); step("r4_drain1", 0, 0, 0, 0, 0);
        clear_in(); wb(1, 4'd4, 32'h99); step("r4_extra_wb", 0, 0, 0, 0, 0);
        clear_in(); instr(32'h400, 4'd4, 1, 4'd5, 1, 4'd8, 0, 0); step("r4_read", 0, 0, 1, 32'h99, 32'd2);

        // Downstream stall holds the latch, then the same instruction issues
        clear_in(); instr(32'h404, 4'd0, 0, 4'd0, 0, 4'd9, 0, 0); bus.I_GPUStallSignal = 1;
        step("gstall", 0, 0, 0, 0, 0);
        chk("hold_pc", bus.O_PC, 32'h400);
        chk("hold_valid", 32'(bus.O_DE_Valid), 32'd1);
        clear_in(); instr(32'h404, 4'd0, 0, 4'd0, 0, 4'd9, 0, 0); step("after_gstall", 0, 0, 1, 0, 0);

        // Branch: resolve is ignored while idle; four unresolved cycles, resolve, issue next cycle
        clear_in(); instr(32'h500, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1); bus.I_BranchResolved = 1;
        step("br_issue", 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            clear_in(); instr(32'h504, 4'd1, 1, 4'd2, 1, 4'd10, 1, 0); step("br_wait", 0, 1, 0, 0, 0);
        end
        clear_in(); instr(32'h504, 4'd1, 1, 4'd2, 1, 4'd10, 1, 0); bus.I_BranchResolved = 1;
        step("br_resolve", 0, 1, 0, 0, 0);
        clear_in(); instr(32'h504, 4'd1, 1, 4'd2, 1, 4'd10, 1, 0); step("br_after", 0, 0, 1, 0, 0);

        // Reset while waiting on a branch with R2 pending and a stall asserted
        clear_in(); instr(32'h600, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0); step("r2_w", 0, 0, 1, 0, 0);
        clear_in(); instr(32'h604, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1); step("br2_issue", 0, 1, 1, 0, 0);
        clear_in(); instr(32'h608, 4'd2, 1, 4'd0, 0, 4'd0, 0, 0); bus.I_GPUStallSignal = 1;
        reset_cycle();
        clear_in(); instr(32'h700, 4'd2, 1, 4'd3, 1, 4'd10, 1, 0); step("post_rst", 0, 0, 1, 0, 0);
        clear_in(); step("idle_a", 0, 0, 0, 0, 0);
        clear_in(); step("idle_b", 0, 0, 0, 0, 0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
